// File: rtl/hazard3_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// HAZARD3_RR_ARBITER_LOCK_EN adds the lock signal for atomic sequences.
interface hazard3_rr_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W_IDX = $clog2(N_REQ)
);
   logic [N_REQ-1:0] req;
   logic             done;
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
   logic             lock;
`endif
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic [W_IDX-1:0] gnt_idx;

   modport master (
      output req,
      output done,
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      output lock,
`endif
      input  gnt,
      input  gnt_valid,
      input  gnt_idx
   );

   modport slave (
      input  req,
      input  done,
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      input  lock,
`endif
      output gnt,
      output gnt_valid,
      output gnt_idx
   );
endinterface

// File: rtl/hazard3_rr_arbiter.sv
// Registered round-robin arbiter; grant held until done.
// HAZARD3_RR_ARBITER_LOCK_EN: done with lock=1 keeps the current grant.
module hazard3_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W_IDX = $clog2(N_REQ)
) (
   input logic                 clk,
   input logic                 rst,
   hazard3_rr_arbiter_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [W_IDX-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [W_IDX-1:0] last_q, last_d;

   logic             release_gnt;
   logic [W_IDX-1:0] arb_last;
   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] mask_hi;
   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] win_oh;
   logic [W_IDX-1:0] win_idx;

   always_comb begin
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      release_gnt = bus.done & ~bus.lock;
`else
      release_gnt = bus.done;
`endif
   end

   // In BUSY the pointer is the current winner, which is excluded so it cannot re-win.
   always_comb begin
      arb_last = (state_q == StBusy) ? gnt_idx_q : last_q;
      arb_req  = (state_q == StBusy) ? (bus.req & ~gnt_q) : bus.req;
      for (int i = 0; i < int'(N_REQ); i++) begin
         mask_hi[i] = (i > int'(arb_last));
      end
      masked = arb_req & mask_hi;
      win_oh = (|masked) ? (masked & (-masked)) : (arb_req & (-arb_req));
      win_idx = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (win_oh[i]) win_idx = W_IDX'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      last_d      = last_q;
      case (state_q)
         StIdle: begin
            if (|arb_req) begin
               gnt_d       = win_oh;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               state_d     = StBusy;
            end
         end
         StBusy: begin
            if (release_gnt) begin
               last_d = gnt_idx_q;
               if (|arb_req) begin
                  gnt_d     = win_oh;
                  gnt_idx_d = win_idx;
               end else begin
                  gnt_d       = '0;
                  gnt_idx_d   = '0;
                  gnt_valid_d = 1'b0;
                  state_d     = StIdle;
               end
            end
         end
         default: begin
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         last_q      <= W_IDX'(N_REQ - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         last_q      <= last_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_hazard3_rr_arbiter.sv
// Self-checking bench for hazard3_rr_arbiter: directed cases then random traffic
// against a circular-search reference model.
module tb_hazard3_rr_arbiter;
   localparam int unsigned N = 4;
   localparam int unsigned W = $clog2(N);
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard3_rr_arbiter_if #(.N_REQ(N)) bus_if ();

   hazard3_rr_arbiter #(.N_REQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit mdl_busy  = 1'b0;
   int mdl_owner = 0;
   int mdl_last  = N - 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // First requester strictly after 'start' going round the ring, skipping 'excl'.
   function automatic int next_from(input int start, input logic [N-1:0] r, input int excl);
      for (int k = 1; k <= int'(N); k++) begin
         int idx;
         idx = (start + k) % int'(N);
         if (idx != excl && r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] rq, input logic d,
                             input logic lk);
      int w;
      if (r) begin
         mdl_busy = 1'b0;
         mdl_last = N - 1;
      end else if (!mdl_busy) begin
         w = next_from(mdl_last, rq, -1);
         if (w >= 0) begin
            mdl_busy  = 1'b1;
            mdl_owner = w;
         end
      end else if (d && !(LOCK_EN && lk)) begin
         mdl_last = mdl_owner;
         w = next_from(mdl_owner, rq, mdl_owner);
         if (w >= 0) mdl_owner = w;
         else mdl_busy = 1'b0;
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] rq, input logic d, input logic lk);
      logic [N-1:0] exp_gnt;
      rst         = r;
      bus_if.req  = rq;
      bus_if.done = d;
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      bus_if.lock = lk;
`endif
      @(posedge clk);
      model_step(r, rq, d, lk);
      #1;
      exp_gnt = mdl_busy ? N'(1 << mdl_owner) : '0;
      check("gnt", bus_if.gnt, exp_gnt);
      check("gnt_valid", bus_if.gnt_valid, mdl_busy);
      check("gnt_idx", bus_if.gnt_idx, mdl_busy ? mdl_owner : 0);
      check("onehot0", $onehot0(bus_if.gnt), 1);
      check("valid_eq_or", bus_if.gnt_valid, |bus_if.gnt);
   endtask

   initial begin
      bus_if.req  = '0;
      bus_if.done = 1'b0;
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      bus_if.lock = 1'b0;
`endif
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      check("reset_gnt", bus_if.gnt, 0);
      check("reset_idx", bus_if.gnt_idx, 0);

      // Basic grant then rotation
      step(1'b0, 4'b0101, 1'b0, 1'b0);
      check("tp1_first", bus_if.gnt, 4'b0001);
      step(1'b0, 4'b0101, 1'b1, 1'b0);
      check("tp1_second", bus_if.gnt, 4'b0100);
      check("tp1_idx", bus_if.gnt_idx, 2);

      // Wrap-around
      step(1'b0, 4'b0011, 1'b1, 1'b0);
      check("tp2_wrap", bus_if.gnt, 4'b0001);

      // Hold while the request is withdrawn
      step(1'b0, 4'b0011, 1'b1, 1'b0);
      check("tp3_setup", bus_if.gnt, 4'b0010);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b0000, 1'b0, 1'b0);
         check("tp3_hold", bus_if.gnt, 4'b0010);
      end
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("tp3_release", bus_if.gnt, 4'b0000);
      check("tp3_valid", bus_if.gnt_valid, 1'b0);

      // Sole requester takes an idle cycle between grants
      step(1'b0, 4'b1000, 1'b0, 1'b0);
      check("tp4_grant", bus_if.gnt, 4'b1000);
      step(1'b0, 4'b1000, 1'b1, 1'b0);
      check("tp4_idle", bus_if.gnt, 4'b0000);
      step(1'b0, 4'b1000, 1'b0, 1'b0);
      check("tp4_regrant", bus_if.gnt, 4'b1000);

      // Reset mid-transaction
      step(1'b0, 4'b0100, 1'b1, 1'b0);
      check("tp5_setup", bus_if.gnt, 4'b0100);
      step(1'b1, 4'b1111, 1'b0, 1'b0);
      check("tp5_rst_gnt", bus_if.gnt, 4'b0000);
      check("tp5_rst_valid", bus_if.gnt_valid, 1'b0);
      step(1'b0, 4'b1111, 1'b0, 1'b0);
      check("tp5_first", bus_if.gnt, 4'b0001);

      // Fairness: sequence 0,1,2,3,0,1,2,3
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 4'b1111, 1'b1, 1'b0);
         check("tp6_fair", bus_if.gnt_idx, k % 4);
      end
      step(1'b0, 4'b1111, 1'b1, 1'b0);
      step(1'b0, 4'b1111, 1'b1, 1'b0);
      check("tp6_at1", bus_if.gnt_idx, 1);
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
      step(1'b0, 4'b1111, 1'b1, 1'b1);
      check("tp6_lock", bus_if.gnt, 4'b0010);
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63) == 0), N'($urandom), ($urandom_range(2) == 0),
              ($urandom_range(3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/hazard3_rr_arbiter.md
Name: hazard3_rr_arbiter

Overview:
- Registered round-robin arbiter for N requesters sharing one downstream resource (e.g. a shared bus port or a debug/DMA access slot).
- Builds a rotated priority mask from the last winner and resolves it with two lowest-set-bit one-hot selectors: masked requests first, unmasked requests as fallback.
- Holds the registered one-hot grant for the whole transaction until the resource signals completion.
- Sits directly upstream of the resource mux; gnt drives the mux select.

Parameters:
- N_REQ, 4, number of requesters (2 to 32).
- W_IDX, $clog2(N_REQ), width of the binary grant index.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  request bitmap, level-sensitive, bit i from requester i.
- done  input  1  transaction complete; releases the current grant.
- gnt  output  N_REQ  registered one-hot grant, all-zero when idle.
- gnt_valid  output  1  registered; high when gnt is non-zero.
- gnt_idx  output  W_IDX  registered binary index of the set bit in gnt; 0 when idle.

Behaviour:
- Reset, synchronous on rst=1 at a rising clk edge:
  - gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE.
  - Last-winner pointer last=N_REQ-1, so index 0 has top priority after reset.
  - Reset has priority over all other inputs, including mid-transaction.
- Arbitration, combinational:
  - mask_hi = bits with index > last.
  - masked = req & mask_hi.
  - winner = lowest set bit of masked if masked is non-zero, else lowest set bit of req.
- State IDLE:
  - If req != 0: register winner into gnt and its index into gnt_idx, set gnt_valid=1, go to BUSY. Latency is 1 cycle from req to gnt.
  - If req == 0: stay in IDLE, outputs stay zero.
  - done is ignored in IDLE.
- State BUSY:
  - gnt, gnt_idx and gnt_valid hold regardless of req; withdrawal of the granted request does not release the grant.
  - On done=1: last <= gnt_idx.
    - If req restricted to bits other than the current winner is non-zero, grant the new winner, computed with the updated mask, at the same edge. This is back-to-back with no idle cycle; stay in BUSY.
    - Otherwise: clear gnt, gnt_idx and gnt_valid, and go to IDLE.
    - The current winner may not re-win on its own done cycle.
- Wrap-around: if no request exists above last, the lowest set bit of req wins. For example, last=3 with req=0011 gives index 0.
- Invariants checked by the bench:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx matches gnt.
  - gnt changes only on a cycle following done, or on leaving IDLE.
- Fairness: with all N_REQ requests continuously asserted, each requester is granted exactly once per N_REQ transactions.

Optional Feature:
- Macro: HAZARD3_RR_ARBITER_LOCK_EN.
- Defined:
  - Extra input port lock (1 bit).
  - done=1 with lock=1 keeps the current grant: no re-arbitration, last unchanged, stay in BUSY.
  - done=1 with lock=0 behaves as described under Behaviour.
  - Used for atomic multi-transaction sequences.
- Undefined: no lock port; every done releases the grant.

Test Plan:
1. After reset, req=0101: next edge gives gnt=0001, gnt_idx=0, gnt_valid=1. Pulse done with req still 0101: next edge gives gnt=0100, gnt_idx=2.
2. Wrap-around: from gnt_idx=2, req=0011, done=1: next edge gives gnt=0001, gnt_idx=0.
3. Hold: gnt=0010, then req drops to 0000 for 5 cycles with done=0: gnt stays 0010. Then done=1: next edge gives gnt=0000, gnt_valid=0, state IDLE.
4. Sole requester: req=1000 only, done=1 while gnt=1000: next edge gives gnt=0000. The following edge re-grants 1000 from IDLE, showing one idle cycle.
5. Reset mid-transaction: gnt=0100, rst=1 for one cycle: gnt=0, gnt_valid=0, gnt_idx=0. With req=1111 afterwards, the first grant is 0001.
6. Fairness and lock: req=1111 held for 8 transactions gives the grant sequence 0,1,2,3,0,1,2,3. With HAZARD3_RR_ARBITER_LOCK_EN defined, done plus lock=1 at gnt_idx=1 gives gnt staying 0010.
